// File: rtl/cpu_pkg.sv
// Shared definitions for the program-control stage: sequencer states,
// opcode encodings and the instruction field layout.
package cpu_pkg;

    localparam int INSTR_W = 8;

    // Instruction field bit positions
    localparam int OPC_HI = 7;
    localparam int OPC_LO = 5;
    localparam int DST    = 4;
    localparam int SRCA   = 3;
    localparam int SRCB   = 2;

    // Opcode encodings; the sequencer passes them through unmodified
    localparam logic [2:0] OP_0 = 3'd0;
    localparam logic [2:0] OP_1 = 3'd1;
    localparam logic [2:0] OP_2 = 3'd2;
    localparam logic [2:0] OP_3 = 3'd3;
    localparam logic [2:0] OP_4 = 3'd4;
    localparam logic [2:0] OP_5 = 3'd5;
    localparam logic [2:0] OP_6 = 3'd6;
    localparam logic [2:0] OP_7 = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        READ   = 3'd3,
        WB     = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program memory: PROG_DEPTH x INSTR_W, synchronous write, asynchronous read.
// Contents survive reset; only the write port changes them.
module prog_mem
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int PROG_DEPTH = 16
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [PROG_DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program-control stage ahead of the register bank and ALU. Steps a PC
// through program memory, spending four cycles per instruction so operand
// read, ALU evaluation and write-back line up with the bank's registers.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int PROG_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
    output logic [INSTR_W-1:0] instr,
    output logic               rd,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done,
    output logic               prog_err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(PROG_DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    seq_state_t         state;
    logic [ADDR_W:0]    len_q;
    logic [ADDR_W:0]    len_clamp;
    logic [ADDR_W:0]    pc_inc;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_we;

    // busy is exactly FETCH..WB, so it doubles as the write-lockout qualifier
    assign mem_we    = prog_we && !busy;
    assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    // One extra bit so pc+1 can be compared against a length of PROG_DEPTH
    assign pc_inc    = {1'b0, pc} + ONE_L;

    prog_mem #(
        .ADDR_W     (ADDR_W),
        .PROG_DEPTH (PROG_DEPTH)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (mem_rdata)
    );

    // Sequencer FSM with registered outputs; rd is set on entry to WB only
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            pc       <= '0;
            instr    <= '0;
            rd       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            prog_err <= 1'b0;
        end else begin
            prog_err <= prog_we && busy;
            rd       <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len_q <= len_clamp;
                        pc    <= '0;
                        if (len_clamp == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    instr <= mem_rdata;
                    state <= DECODE;
                end
                DECODE: begin
                    state <= READ;
                end
                READ: begin
                    state <= WB;
                    rd    <= 1'b1;
                end
                WB: begin
                    pc <= pc_inc[ADDR_W-1:0];
                    if (pc_inc == len_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
